// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding memory requests
// and drives the IF/ID register with stall handling, branch redirects and bubbles.
module fetch_stage #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [INSTR_W-1:0] BUBBLE   = 32'h4A00_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic               id_valid,
    output logic [1:0]         instruction_type,
    output logic [4:0]         opcode
);

    typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_HOLD} state_t;

    state_t             state, state_n;
    logic [ADDR_W-1:0]  pc, pc_n;
    logic               discard, discard_n;
    logic [INSTR_W-1:0] buf_instr;
    logic [ADDR_W-1:0]  buf_pc;
    logic               buf_ld;
    logic [INSTR_W-1:0] id_instr_n;
    logic [ADDR_W-1:0]  id_pc_n;
    logic               id_valid_n;

    assign imem_req_valid   = !rst && (state == ST_REQ) && !branch_taken;
    assign imem_req_addr    = pc;
    assign instruction_type = id_instr[31:30];
    assign opcode           = id_instr[29:25];

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        discard_n  = discard;
        buf_ld     = 1'b0;
        id_instr_n = id_instr;
        id_pc_n    = id_pc;
        id_valid_n = id_valid;

        if (branch_taken) begin
            pc_n       = branch_target;
            id_instr_n = BUBBLE;
            id_pc_n    = '0;
            id_valid_n = 1'b0;
            state_n    = ST_REQ;
            discard_n  = 1'b0;
            // The in-flight word still has to come back; wait for it and drop it.
            if (state == ST_WAIT && !imem_resp_valid) begin
                state_n   = ST_WAIT;
                discard_n = 1'b1;
            end
        end else begin
            case (state)
                ST_REQ: begin
                    if (imem_req_valid && imem_req_ready)
                        state_n = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        state_n = ST_REQ;
                        if (discard) begin
                            discard_n = 1'b0;
                        end else if (!stall) begin
                            id_instr_n = imem_resp_data;
                            id_pc_n    = pc;
                            id_valid_n = 1'b1;
                            pc_n       = pc + ADDR_W'(4);
                        end else begin
                            buf_ld  = 1'b1;
                            pc_n    = pc + ADDR_W'(4);
                            state_n = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        id_instr_n = buf_instr;
                        id_pc_n    = buf_pc;
                        id_valid_n = 1'b1;
                        state_n    = ST_REQ;
                    end
                end
                default: state_n = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_REQ;
            pc       <= RESET_PC;
            discard  <= 1'b0;
            id_instr <= BUBBLE;
            id_pc    <= '0;
            id_valid <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            discard  <= discard_n;
            id_instr <= id_instr_n;
            id_pc    <= id_pc_n;
            id_valid <= id_valid_n;
        end
    end

    // Skid buffer contents are only meaningful in HOLD, so they need no reset.
    always_ff @(posedge clk) begin
        if (buf_ld) begin
            buf_instr <= imem_resp_data;
            buf_pc    <= pc;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run checked
// against a flag-based behavioural model and a single-outstanding memory model.
module tb_fetch_stage;

    localparam logic [31:0] BUB = 32'h4A00_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_valid;
    logic [1:0]  instruction_type;
    logic [4:0]  opcode;

    int total = 0;
    int bad = 0;

    fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .BUBBLE(BUB)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid),
        .instruction_type(instruction_type), .opcode(opcode)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_pc = '0, m_id = BUB, m_idpc = '0, m_hw = '0, m_hpc = '0, m_paddr = '0;
    logic        m_idv = 1'b0, m_out = 1'b0, m_disc = 1'b0, m_held = 1'b0;
    int          m_cnt = 0;
    int          lat = 1;
    bit          rand_lat = 0;
    bit          spur_en = 0;
    logic        obs_rv, exp_rv;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F0F;
    endfunction

    // Drive one clock cycle of inputs, advance the model, return at the next negedge.
    task automatic cycle(input logic r, input logic st, input logic br,
                         input logic [31:0] tgt, input logic rdy);
        logic        rv, resp_now;
        logic [31:0] rd;
        rv = 1'b0;
        rd = $urandom;
        resp_now = m_out && (m_cnt == 0);
        if (resp_now) begin
            rv = 1'b1;
            rd = tag(m_paddr);
        end else if (spur_en && !m_out && $urandom_range(0, 9) == 0) begin
            rv = 1'b1;
        end
        rst = r; stall = st; branch_taken = br; branch_target = tgt;
        imem_req_ready = rdy; imem_resp_valid = rv; imem_resp_data = rd;
        #1;
        obs_rv = imem_req_valid;
        exp_rv = !r && !m_out && !m_held && !br;
        if (r) begin
            m_pc = '0; m_out = 0; m_disc = 0; m_held = 0;
            m_id = BUB; m_idpc = '0; m_idv = 0;
        end else begin
            if (m_out && !resp_now) m_cnt--;
            if (br) begin
                m_pc = tgt; m_id = BUB; m_idpc = '0; m_idv = 0; m_held = 0;
                if (m_out) begin
                    if (resp_now) begin m_out = 0; m_disc = 0; end
                    else m_disc = 1;
                end
            end else if (m_held) begin
                if (!st) begin m_id = m_hw; m_idpc = m_hpc; m_idv = 1; m_held = 0; end
            end else if (m_out) begin
                if (resp_now) begin
                    m_out = 0;
                    if (m_disc) m_disc = 0;
                    else if (!st) begin m_id = rd; m_idpc = m_pc; m_idv = 1; m_pc = m_pc + 4; end
                    else begin m_held = 1; m_hw = rd; m_hpc = m_pc; m_pc = m_pc + 4; end
                end
            end else if (rdy) begin
                m_out = 1; m_paddr = m_pc;
                m_cnt = rand_lat ? $urandom_range(0, 2) : lat - 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        total++; if (obs_rv !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b exp=0", obs_rv); end
        total++; if (id_instr !== BUB) begin bad++; $display("FAIL rst_id_instr got=%h exp=%h", id_instr, BUB); end
        total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL rst_id_pc got=%h exp=0", id_pc); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rst_id_valid got=%b exp=0", id_valid); end
        total++; if (instruction_type !== 2'b01) begin bad++; $display("FAIL rst_type got=%b exp=01", instruction_type); end
        total++; if (opcode !== 5'b00101) begin bad++; $display("FAIL rst_opcode got=%b exp=00101", opcode); end
        total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", imem_req_addr); end
    endtask

    task automatic test_free_run();
        logic [31:0] w;
        lat = 1;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 1);
            total++; if (obs_rv !== 1'b1) begin bad++; $display("FAIL free_req_valid i=%0d got=%b exp=1", i, obs_rv); end
            cycle(0, 0, 0, 0, 1);
            w = tag(32'(4 * i));
            total++; if (id_pc !== 32'(4 * i)) begin bad++; $display("FAIL free_id_pc got=%h exp=%h", id_pc, 32'(4 * i)); end
            total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL free_id_valid got=%b exp=1", id_valid); end
            total++; if (id_instr !== w) begin bad++; $display("FAIL free_id_instr got=%h exp=%h", id_instr, w); end
            total++; if (opcode !== w[29:25]) begin bad++; $display("FAIL free_opcode got=%b exp=%b", opcode, w[29:25]); end
            total++; if (imem_req_addr !== 32'(4 * i + 4)) begin bad++; $display("FAIL free_addr got=%h exp=%h", imem_req_addr, 32'(4 * i + 4)); end
        end
    endtask

    task automatic test_stall();
        cycle(0, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 1);
        total++; if (id_pc !== 32'h8) begin bad++; $display("FAIL stall_hold_pc got=%h exp=8", id_pc); end
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1, 0, 0, 1);
            total++; if (obs_rv !== 1'b0) begin bad++; $display("FAIL stall_no_req got=%b exp=0", obs_rv); end
            total++; if (id_instr !== tag(32'h8)) begin bad++; $display("FAIL stall_hold_instr got=%h exp=%h", id_instr, tag(32'h8)); end
        end
        cycle(0, 0, 0, 0, 1);
        total++; if (obs_rv !== 1'b0) begin bad++; $display("FAIL stall_release_req got=%b exp=0", obs_rv); end
        total++; if (id_pc !== 32'hC || id_valid !== 1'b1) begin bad++; $display("FAIL stall_buf_out got=%h/%b exp=c/1", id_pc, id_valid); end
        total++; if (id_instr !== tag(32'hC)) begin bad++; $display("FAIL stall_buf_instr got=%h exp=%h", id_instr, tag(32'hC)); end
        total++; if (imem_req_addr !== 32'h10) begin bad++; $display("FAIL stall_next_addr got=%h exp=10", imem_req_addr); end
        cycle(0, 0, 0, 0, 1);
        total++; if (obs_rv !== 1'b1) begin bad++; $display("FAIL stall_resume_req got=%b exp=1", obs_rv); end
        cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_branch_wait();
        cycle(0, 0, 1, 32'h10, 1);
        total++; if (obs_rv !== 1'b0) begin bad++; $display("FAIL bw_withdraw got=%b exp=0", obs_rv); end
        total++; if (imem_req_addr !== 32'h10) begin bad++; $display("FAIL bw_addr10 got=%h exp=10", imem_req_addr); end
        lat = 3;
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 1, 32'h40, 1);
        total++; if (id_instr !== BUB || id_valid !== 1'b0) begin bad++; $display("FAIL bw_bubble got=%h/%b exp=%h/0", id_instr, id_valid, BUB); end
        total++; if (opcode !== 5'b00101) begin bad++; $display("FAIL bw_opcode got=%b exp=00101", opcode); end
        for (int i = 0; i < 2; i++) begin
            cycle(0, 0, 0, 0, 1);
            total++; if (obs_rv !== 1'b0) begin bad++; $display("FAIL bw_wait_req i=%0d got=%b exp=0", i, obs_rv); end
            total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL bw_stale i=%0d got=%b exp=0", i, id_valid); end
        end
        lat = 1;
        total++; if (imem_req_addr !== 32'h40) begin bad++; $display("FAIL bw_target got=%h exp=40", imem_req_addr); end
        cycle(0, 0, 0, 0, 1);
        total++; if (obs_rv !== 1'b1) begin bad++; $display("FAIL bw_req_target got=%b exp=1", obs_rv); end
        cycle(0, 0, 0, 0, 1);
        total++; if (id_pc !== 32'h40 || id_instr !== tag(32'h40)) begin bad++; $display("FAIL bw_fetch got=%h/%h exp=40/%h", id_pc, id_instr, tag(32'h40)); end
    endtask

    task automatic test_branch_resp_stall();
        cycle(0, 0, 0, 0, 1);
        cycle(0, 1, 1, 32'h80, 1);
        total++; if (id_instr !== BUB || id_valid !== 1'b0 || id_pc !== 32'h0) begin bad++; $display("FAIL brs_bubble got=%h/%b/%h exp=%h/0/0", id_instr, id_valid, id_pc, BUB); end
        total++; if (imem_req_addr !== 32'h80) begin bad++; $display("FAIL brs_addr got=%h exp=80", imem_req_addr); end
        cycle(0, 1, 0, 0, 1);
        total++; if (obs_rv !== 1'b1) begin bad++; $display("FAIL brs_req got=%b exp=1", obs_rv); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL brs_no_stale got=%b exp=0", id_valid); end
        cycle(0, 0, 0, 0, 1);
        total++; if (id_pc !== 32'h80 || id_instr !== tag(32'h80)) begin bad++; $display("FAIL brs_fetch got=%h/%h exp=80/%h", id_pc, id_instr, tag(32'h80)); end
    endtask

    task automatic test_wrap();
        cycle(0, 0, 1, 32'hFFFF_FFFC, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        total++; if (id_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_id_pc got=%h exp=fffffffc", id_pc); end
        total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h exp=0", imem_req_addr); end
    endtask

    task automatic test_reset_hold();
        cycle(0, 0, 1, 32'h100, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 1);
        cycle(1, 1, 0, 0, 1);
        total++; if (obs_rv !== 1'b0) begin bad++; $display("FAIL rh_rst_req got=%b exp=0", obs_rv); end
        total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL rh_pc got=%h exp=0", imem_req_addr); end
        total++; if (id_valid !== 1'b0 || id_instr !== BUB) begin bad++; $display("FAIL rh_id got=%h/%b exp=%h/0", id_instr, id_valid, BUB); end
        cycle(0, 0, 0, 0, 1);
        total++; if (obs_rv !== 1'b1) begin bad++; $display("FAIL rh_req_after got=%b exp=1", obs_rv); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rh_buf_empty got=%b exp=0", id_valid); end
        cycle(0, 0, 0, 0, 1);
        total++; if (id_pc !== 32'h0 || id_instr !== tag(32'h0)) begin bad++; $display("FAIL rh_fetch got=%h/%h exp=0/%h", id_pc, id_instr, tag(32'h0)); end
    endtask

    task automatic test_random();
        logic        r, st, br, rdy;
        logic [31:0] tgt;
        logic [31:0] w;
        rand_lat = 1;
        spur_en = 1;
        cycle(1, 0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 99) == 0);
            st  = ($urandom_range(0, 9) < 3);
            br  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | ($urandom & 32'hC);
            else tgt = $urandom & 32'h0000_0FFC;
            cycle(r, st, br, tgt, rdy);
            w = m_id;
            total++; if (obs_rv !== exp_rv) begin bad++; if (bad < 20) $display("FAIL rnd_req_valid i=%0d got=%b exp=%b", i, obs_rv, exp_rv); end
            total++; if (imem_req_addr !== m_pc) begin bad++; if (bad < 20) $display("FAIL rnd_addr i=%0d got=%h exp=%h", i, imem_req_addr, m_pc); end
            total++; if (id_instr !== m_id) begin bad++; if (bad < 20) $display("FAIL rnd_id_instr i=%0d got=%h exp=%h", i, id_instr, m_id); end
            total++; if (id_pc !== m_idpc) begin bad++; if (bad < 20) $display("FAIL rnd_id_pc i=%0d got=%h exp=%h", i, id_pc, m_idpc); end
            total++; if (id_valid !== m_idv) begin bad++; if (bad < 20) $display("FAIL rnd_id_valid i=%0d got=%b exp=%b", i, id_valid, m_idv); end
            total++; if (opcode !== w[29:25] || instruction_type !== w[31:30]) begin bad++; if (bad < 20) $display("FAIL rnd_fields i=%0d got=%b/%b exp=%b/%b", i, instruction_type, opcode, w[31:30], w[29:25]); end
        end
        rand_lat = 0;
        spur_en = 0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_free_run();
        test_stall();
        test_branch_wait();
        test_branch_resp_stall();
        test_wrap();
        test_reset_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
